// File: rtl/kmac_pkg.sv
// Shared KMAC message-path types: message FIFO FSM states and source channel indices.
package kmac_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLocked = 2'd1,
      StFlush  = 2'd2,
      StDone   = 2'd3
   } msgfifo_st_e;

   localparam int MsgChSw     = 0;
   localparam int MsgChKeyMgr = 1;
   localparam int MsgChApp    = 2;
   localparam int MaxMsgCh    = 8;

endpackage

// File: rtl/kmac_msgfifo_arb.sv
// Fixed-priority arbiter: locks the lowest-index requester until released.
// Grant registered one cycle after lock_en_i; release_i overrides a same-cycle lock.
module kmac_msgfifo_arb #(
   parameter int NumCh = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [NumCh-1:0] req_i,
   input  logic             lock_en_i,
   input  logic             release_i,
   output logic [NumCh-1:0] grant_o
);

   logic [NumCh-1:0] grant_q, grant_d;
   logic [NumCh-1:0] win;

   // Walk from the top so the last hit, the lowest index, is the one kept.
   always_comb begin
      win = '0;
      for (int c = NumCh - 1; c >= 0; c--) begin
         if (req_i[c]) begin
            win    = '0;
            win[c] = 1'b1;
         end
      end
   end

   always_comb begin
      grant_d = grant_q;
      if (release_i) begin
         grant_d = '0;
      end else if (lock_en_i && (grant_q == '0)) begin
         grant_d = win;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         grant_q <= '0;
      end else begin
         grant_q <= grant_d;
      end
   end

   assign grant_o = grant_q;

endmodule

// File: rtl/kmac_msgfifo_mc.sv
// Multi-channel KMAC message FIFO: locks one source per hash, buffers its words, merges process requests.
// 1-cycle push-to-head latency; ready only toward the granted channel while not full. Option: KMAC_MSGFIFO_ERR_EN.
module kmac_msgfifo_mc
   import kmac_pkg::*;
#(
   parameter int DataW  = 64,
   parameter int Depth  = 9,
   parameter int NumCh  = 3,
   parameter int DepthW = $clog2(Depth + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NumCh-1:0]       ch_valid_i,
   input  logic [NumCh*DataW-1:0] ch_data_i,
   input  logic [NumCh*DataW-1:0] ch_mask_i,
   output logic [NumCh-1:0]       ch_ready_o,
   input  logic [NumCh-1:0]       ch_process_i,
   output logic [NumCh-1:0]       grant_o,
   output logic                   busy_o,
   output logic                   msg_valid_o,
   output logic [DataW-1:0]       msg_data_o,
   output logic [DataW/8-1:0]     msg_strb_o,
   input  logic                   msg_ready_i,
   output logic                   fifo_empty_o,
   output logic                   fifo_full_o,
   output logic [DepthW-1:0]      fifo_depth_o,
   input  logic                   clear_i,
   output logic                   process_o
`ifdef KMAC_MSGFIFO_ERR_EN
   ,
   output logic                   err_o,
   output logic [NumCh-1:0]       err_ch_o
`endif
);

   localparam int StrbW = DataW / 8;
   localparam int PtrW  = $clog2(Depth);

   typedef struct packed {
      logic [DataW-1:0] data;
      logic [StrbW-1:0] strb;
   } entry_t;

   msgfifo_st_e       st_q, st_d;
   logic              process_q, process_d;
   entry_t            mem_q [Depth];
   entry_t            mem_d [Depth];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DepthW-1:0] cnt_q, cnt_d;

   logic [NumCh-1:0]  req, grant;
   logic              lock_en, full, empty, push, pop;
   logic              sel_vld, sel_proc, empty_msg, found;
   logic [DataW-1:0]  sel_dat, sel_msk;
   entry_t            wr_entry;
   logic              unused_msk;

`ifdef KMAC_MSGFIFO_ERR_EN
   logic              err_q, err_d;
   logic [NumCh-1:0]  err_ch_q, err_ch_d, bad;
`endif

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign req     = ch_valid_i | ch_process_i;
   assign lock_en = (st_q == StIdle) && !clear_i;

   kmac_msgfifo_arb #(
      .NumCh (NumCh)
   ) u_arb (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (req),
      .lock_en_i (lock_en),
      .release_i (clear_i),
      .grant_o   (grant)
   );

   // A lone process pulse from the winning channel means an empty message.
   always_comb begin
      found     = 1'b0;
      empty_msg = 1'b0;
      for (int c = 0; c < NumCh; c++) begin
         if (!found && req[c]) begin
            found     = 1'b1;
            empty_msg = ch_process_i[c] & ~ch_valid_i[c];
         end
      end
   end

   always_comb begin
      sel_dat = '0;
      sel_msk = '0;
      for (int c = 0; c < NumCh; c++) begin
         if (grant[c]) begin
            sel_dat = sel_dat | ch_data_i[c*DataW +: DataW];
            sel_msk = sel_msk | ch_mask_i[c*DataW +: DataW];
         end
      end
      wr_entry.data = sel_dat;
      for (int i = 0; i < StrbW; i++) begin
         wr_entry.strb[i] = sel_msk[8*i];
      end
   end

   assign unused_msk = ^sel_msk;
   assign sel_vld    = |(ch_valid_i & grant);
   assign sel_proc   = |(ch_process_i & grant);

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == DepthW'(Depth));
   assign push  = (st_q == StLocked) && sel_vld && !full && !clear_i;
   assign pop   = !empty && msg_ready_i && !clear_i;

`ifdef KMAC_MSGFIFO_ERR_EN
   // Offending words are flagged and consumed so the source does not stall.
   always_comb begin
      bad = '0;
      if (st_q != StIdle) begin
         bad = ch_valid_i & ~grant;
      end
      if ((st_q == StFlush) || (st_q == StDone)) begin
         bad = ch_valid_i;
      end
      err_ch_d = clear_i ? '0 : (err_ch_q | bad);
      err_d    = clear_i ? 1'b0 : (err_q | (|bad));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q    <= 1'b0;
         err_ch_q <= '0;
      end else begin
         err_q    <= err_d;
         err_ch_q <= err_ch_d;
      end
   end

   assign err_o    = err_q;
   assign err_ch_o = err_ch_q;
`endif

   always_comb begin
      ch_ready_o = '0;
      if ((st_q == StLocked) && !full) begin
         ch_ready_o = grant;
      end
`ifdef KMAC_MSGFIFO_ERR_EN
      ch_ready_o = ch_ready_o | bad;
`endif
   end

   always_comb begin
      st_d      = st_q;
      process_d = 1'b0;
      unique case (st_q)
         StIdle: begin
            if (|req) begin
               st_d = empty_msg ? StFlush : StLocked;
            end
         end
         StLocked: begin
            if (sel_proc) begin
               st_d = StFlush;
            end
         end
         StFlush: begin
            if (empty) begin
               st_d      = StDone;
               process_d = 1'b1;
            end
         end
         StDone: begin
            st_d = StDone;
         end
         default: st_d = StIdle;
      endcase
      if (clear_i) begin
         st_d      = StIdle;
         process_d = 1'b0;
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         cnt_d = cnt_q + DepthW'(push) - DepthW'(pop);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_q      <= StIdle;
         process_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         st_q      <= st_d;
         process_q <= process_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         mem_q     <= mem_d;
      end
   end

   assign grant_o      = grant;
   assign busy_o       = (st_q != StIdle);
   assign msg_valid_o  = !empty;
   assign msg_data_o   = mem_q[rd_ptr_q].data;
   assign msg_strb_o   = mem_q[rd_ptr_q].strb;
   assign fifo_empty_o = empty;
   assign fifo_full_o  = full;
   assign fifo_depth_o = cnt_q;
   assign process_o    = process_q;

endmodule

// File: doc/kmac_msgfifo_mc.md
Name: kmac_msgfifo_mc

Overview:
Multi-channel successor of the KMAC message FIFO. It accepts message words from NumCh independent sources (e.g. SW register path, KeyMgr, app interface) and locks onto one source per hash operation. Words are buffered in a parametrised registered FIFO and presented on the single MSG interface toward the SHA3 datapath. Per-channel process requests are merged into one flush sequence ending in a process_o pulse.

Parameters:
DataW, 64, message word width; multiple of 8
Depth, 9, FIFO entries; >= 2
NumCh, 3, number of input channels; 1..8
DepthW, $clog2(Depth+1), derived; width of the depth count

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ch_valid_i  in  NumCh  per-channel word valid
ch_data_i  in  NumCh*DataW  per-channel data; channel c at [c*DataW +: DataW]
ch_mask_i  in  NumCh*DataW  per-channel bit mask; same packing as ch_data_i
ch_ready_o  out  NumCh  per-channel ready
ch_process_i  in  NumCh  per-channel end-of-message pulse
grant_o  out  NumCh  one-hot locked channel; 0 when idle
busy_o  out  1  FSM not in StIdle
msg_valid_o  out  1  FIFO head valid
msg_data_o  out  DataW  FIFO head data
msg_strb_o  out  DataW/8  FIFO head byte strobe
msg_ready_i  in  1  consumer pop
fifo_empty_o  out  1  count == 0
fifo_full_o  out  1  count == Depth
fifo_depth_o  out  DepthW  current entry count
clear_i  in  1  end-of-operation clear
process_o  out  1  one-cycle pulse: all words of the locked message drained

Behaviour:
- Reset: FSM StIdle; FIFO count 0; all outputs 0 except fifo_empty_o=1.
- FSM states: StIdle, StLocked, StFlush, StDone.
- StIdle:
  - Requesters are channels with ch_valid_i or ch_process_i asserted.
  - The lowest-index requester wins and grant_o is registered next cycle.
  - If the winner's process_i was high and valid_i low: go to StFlush (empty message).
  - Otherwise go to StLocked.
  - No word is accepted in the grant cycle; ch_ready_o is all 0 in StIdle.
- StLocked:
  - ch_ready_o[g] = !fifo_full_o. All other ready bits are 0.
  - Push = ch_valid_i[g] & ch_ready_o[g].
  - Entry strb[i] = mask[8*i]; data is stored unchanged.
  - ch_process_i[g] moves to StFlush. A push in that same cycle is still accepted.
  - Process pulses from non-granted channels are ignored.
- StFlush:
  - All ready bits are 0.
  - When count == 0: assert process_o for one cycle and go to StDone.
- StDone: hold grant_o; wait for clear_i, then go to StIdle.
- FIFO:
  - Registered, no pass-through. A pushed word appears on msg_valid_o the next cycle.
  - Pop = msg_valid_o & msg_ready_i.
  - Ready is computed from the current count, so a full FIFO with a same-cycle pop does not accept a push.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap at Depth; non-power-of-2 Depth is supported.
- clear_i in any state, highest priority:
  - Next cycle: count 0, FSM StIdle, grant_o 0.
  - A push or pop in the clear cycle is discarded.
  - A process_o pulse due in the clear cycle is suppressed.
- Reset asserted mid-operation returns the block to its reset values immediately (asynchronous).

Optional Feature:
KMAC_MSGFIFO_ERR_EN
- Defined:
  - Adds output err_o (1) and err_ch_o (NumCh).
  - err_o sets sticky when a non-granted channel asserts valid in StLocked, StFlush or StDone.
  - err_o also sets when the granted channel asserts valid in StFlush or StDone.
  - err_ch_o accumulates the offending channel bits.
  - Both clear on clear_i.
  - Offending words are dropped; normal operation continues.
- Undefined: ports and logic are absent; such words are silently stalled (ready 0).

Decomposition:
- kmac_pkg additions:
  - msgfifo_st_e as a 2-bit enum.
  - Channel index constants MsgChSw=0, MsgChKeyMgr=1, MsgChApp=2.
  - MaxMsgCh=8.
- The fifo entry struct stays local to the module, since it depends on DataW.
- Sub-module kmac_msgfifo_arb: fixed-priority, lock-until-release arbiter.
  - Inputs: req, lock_en, release.
  - Output: one-hot registered grant.

Test Plan:
- Arbitration: ch1 and ch2 valid together in StIdle -> grant_o=3'b010 next cycle; ch2 ready stays 0; 4 ch1 words 0x11..0x44 emerge in order with strb 0xFF.
- Fill: msg_ready_i=0, push 9 words -> fifo_full_o=1, fifo_depth_o=9, ready 0. Pop and push in the same cycle -> the push is refused, depth becomes 8.
- Partial word and process: last word mask 0x0000_0000_00FF_FFFF with process_i in the same cycle -> word accepted with strb 0x07; process_o pulses exactly once, the cycle the FIFO empties.
- Empty message: ch0 process_i only in StIdle -> grant 3'b001, StFlush, process_o one cycle later; no msg_valid_o.
- Clear mid-message: 3 words buffered, clear_i -> depth 0, grant_o 0, busy_o 0 next cycle, no process_o.
- With ERR_EN: ch2 valid while ch0 is locked -> err_o=1, err_ch_o=3'b100, word dropped; clear_i resets both.
